// File: rtl/sliding_window_gen.sv
// sliding_window_gen: streaming WIN x WIN neighbourhood generator over a
// raster pixel stream, emitting only windows that lie fully inside the image.
//
// Ports:
//   clk, n_rst   rising-edge clock, asynchronous active-low reset
//   clear        synchronous flush of position counters and output valid
//   in_valid     pixel beat valid
//   in_ready     block can take a pixel (!out_valid || out_ready)
//   in_sof       start of frame, marks pixel (0,0) when qualified
//   in_data      pixel value
//   out_valid    out_window holds a complete window
//   out_ready    downstream takes the window
//   out_window   row-major window, element i at [i*DATA_W +: DATA_W],
//                i=0 top-left, i=WIN*WIN-1 bottom-right (newest pixel)
//   out_last     with out_valid: last window of the frame
//   frame_done   one-cycle pulse after the last pixel of a frame is taken
module sliding_window_gen #(
    parameter int DATA_W = 8,
    parameter int WIN    = 3,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sof,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIN*WIN*DATA_W-1:0]  out_window,
    output logic                       out_last,
    output logic                       frame_done
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LB_W  = (WIN - 1) * DATA_W;
    localparam int WIN_W = WIN * WIN * DATA_W;

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_MIN = COL_W'(WIN - 1);
    localparam logic [ROW_W-1:0] ROW_MIN = ROW_W'(WIN - 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] c_eff;
    logic [ROW_W-1:0] r_eff;

    logic             accept;
    logic             col_last;
    logic             row_last;
    logic             emit;

    // All WIN-1 line buffers share one address, so they live in one wide
    // RAM: slot k of a word is lb[k] for that column.
    logic [LB_W-1:0]  lb_mem [IMG_W];
    logic [LB_W-1:0]  lb_rd;
    logic [LB_W-1:0]  lb_wr;

    logic [WIN*DATA_W-1:0] new_col;
    logic [WIN_W-1:0]      win_q;
    logic [WIN_W-1:0]      win_next;

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready && !clear;

    assign c_eff      = in_sof ? '0 : col;
    assign r_eff      = in_sof ? '0 : row;

    assign col_last   = (c_eff == COL_MAX);
    assign row_last   = (r_eff == ROW_MAX);
    assign emit       = (c_eff >= COL_MIN) && (r_eff >= ROW_MIN);

    assign out_window = win_q;

    assign lb_rd      = lb_mem[c_eff];
    // Push the column down one line: lb[k] <= lb[k-1], lb[0] <= in_data.
    assign lb_wr      = {lb_rd[LB_W-DATA_W-1:0], in_data};

    // Right-hand column, top to bottom: oldest line first, newest pixel last.
    always_comb begin
        new_col = '0;
        for (int y = 0; y < WIN - 1; y++) begin
            new_col[y*DATA_W +: DATA_W] =
                lb_rd[(WIN-2-y)*DATA_W +: DATA_W];
        end
        new_col[(WIN-1)*DATA_W +: DATA_W] = in_data;
    end

    always_comb begin
        win_next = win_q;
        for (int y = 0; y < WIN; y++) begin
            for (int x = 0; x < WIN - 1; x++) begin
                win_next[(y*WIN + x)*DATA_W +: DATA_W] =
                    win_q[(y*WIN + x + 1)*DATA_W +: DATA_W];
            end
            win_next[(y*WIN + WIN - 1)*DATA_W +: DATA_W] =
                new_col[y*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb_mem[c_eff] <= lb_wr;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : r_eff + 1'b1;
            end else begin
                col <= c_eff + 1'b1;
                row <= r_eff;
            end
        end
    end

    // The window register doubles as the output stage: it only shifts on
    // accept, and accept is blocked while a window is held.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            win_q <= '0;
        end else if (accept) begin
            win_q <= win_next;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else if (clear) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && col_last && row_last;
            if (accept) begin
                out_valid <= emit;
                out_last  <= emit && col_last && row_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sliding_window_gen.md
Name: sliding_window_gen

Overview:
- Streaming K×K neighbourhood generator for the Sobel/convolution datapath.
- Accepts a raster-order pixel stream (one pixel per beat, valid/ready) and holds K-1 full-line buffers plus a K×K register window.
- Emits every fully-inside-image window (no padding) with valid/ready backpressure.
- Generalises the 3×3 shift/read window buffer in pixel width, kernel size and image geometry; the caller no longer steps shifts.

Parameters:
- DATA_W, 8, pixel width in bits.
- WIN, 3, window edge K. Odd, 3..7.
- IMG_W, 640, pixels per line. Must be ≥ WIN.
- IMG_H, 480, lines per frame. Must be ≥ WIN.

Ports:
- clk  in  1  clock, rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous flush: counters to 0, out_valid to 0.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel.
- in_sof  in  1  start of frame, qualified with in_valid; marks pixel (0,0).
- in_data  in  DATA_W  pixel value.
- out_valid  out  1  window valid.
- out_ready  in  1  downstream accepts the window.
- out_window  out  WIN*WIN*DATA_W  row-major window. Element i sits at bits [i*DATA_W +: DATA_W]. i=0 is top-left, i=WIN*WIN-1 is bottom-right (the newest pixel).
- out_last  out  1  with out_valid: last window of the frame.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (n_rst=0, async): col=0, row=0, out_valid=0, out_last=0, frame_done=0, window registers 0. Line-buffer RAM is not reset; its contents are don't-care.
- in_ready = !out_valid || out_ready, combinational. Single output register stage.
- Accept: in_valid && in_ready. Effective position (c,r) = (0,0) if in_sof, otherwise the current (col,row).
- On accept at column c:
  - Every window row shifts one column left.
  - The new right-hand column, top to bottom, is {lb[WIN-2][c], ..., lb[0][c], in_data}.
  - lb[k][c] <= lb[k-1][c] for k ≥ 1; lb[0][c] <= in_data.
  - Counter advance: c == IMG_W-1 wraps to 0 and increments r; r == IMG_H-1 with c == IMG_W-1 wraps both to 0.
- Latency: 1 cycle. If the accepted pixel has r ≥ WIN-1 and c ≥ WIN-1, out_valid=1 on the next cycle with that window.
- out_last=1 when that pixel is (IMG_W-1, IMG_H-1). frame_done pulses in the same cycle.
- Windows per frame = (IMG_W-WIN+1)*(IMG_H-WIN+1). Pixels with c < WIN-1 load window columns but emit nothing, so windows never straddle lines.
- Output hold: out_valid && !out_ready holds out_window/out_last stable and in_ready=0. No pixel is lost or duplicated under backpressure.
- out_valid clears after a handshake unless a new window loads in the same cycle.
- in_sof mid-frame: the partial frame is abandoned without flagging. Counters restart at (0,0) with the sof pixel. No window is emitted until row WIN-1, so stale line data never reaches the output.
- in_sof on pixel (0,0) of a normal frame: no effect.
- clear has priority over accept in the same cycle: the pixel is dropped and out_valid=0.
- Widths: col is clog2(IMG_W) bits, row is clog2(IMG_H) bits. No arithmetic on pixel data.
- Line buffers: inferred RAM, one read and one write per accept.

Test Plan:
- WIN=3, IMG_W=5, IMG_H=4, pixel=r*16+c, out_ready=1 → first out_valid one cycle after pixel 0x22. Window = 00,01,02,10,11,12,20,21,22. Exactly 6 windows in total; last window = 12,13,14,22,23,24,32,33,34 with out_last=1 and frame_done pulsing once.
- Same frame with out_ready toggled on a 1-of-3 pattern → same 6 windows, bit-identical and in order. in_ready=0 whenever out_valid && !out_ready.
- Two back-to-back frames with pixel=r*16+c+0x80 in frame 2 → frame 2 first window = 80,81,82,90,91,92,A0,A1,A2. No window mixes data from both frames.
- in_sof asserted at frame-1 pixel (1,2) → counters restart; the next 6 windows match a fresh frame; no out_last from the aborted frame.
- n_rst pulsed low mid-frame (async, between edges) → out_valid=0 immediately. A following full frame yields the correct 6 windows.
- WIN=5, IMG_W=IMG_H=6 → exactly 4 windows; the first holds pixels r,c ∈ 0..4 in row-major order.
